// File: rtl/reservoir_fill_controller.sv
// Inlet-valve controller for the irrigation reservoir: hysteresis filling
// between LOW_MARK and HIGH_MARK, minimum valve on/off times, and a latched
// fault when the level fails to rise while the valve is open.
module reservoir_fill_controller #(
    parameter int unsigned LOW_MARK     = 2,
    parameter int unsigned HIGH_MARK    = 6,
    parameter int unsigned MIN_ON       = 4,
    parameter int unsigned MIN_OFF      = 4,
    parameter int unsigned RISE_TIMEOUT = 16,
    parameter int unsigned TW           = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] level,
    input  logic       fault_clear,
    output logic       valve_open,
    output logic       fault,
    output logic [1:0] state,
    output logic [7:0] fill_count
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_FILL  = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    localparam logic [TW-1:0] T_MAX      = '1;
    localparam logic [TW-1:0] MIN_ON_M1  = TW'(MIN_ON - 1);
    localparam logic [TW-1:0] MIN_OFF_M1 = TW'(MIN_OFF - 1);
    localparam logic [TW-1:0] RISE_TO_M1 = TW'(RISE_TIMEOUT - 1);
    localparam logic [2:0]    LOW_LVL    = 3'(LOW_MARK);
    localparam logic [2:0]    HIGH_LVL   = 3'(HIGH_MARK);

    state_e        state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [TW-1:0] rise_t_q, rise_t_d;
    logic [2:0]    level_q;
    logic [7:0]    fill_count_q, fill_count_d;
    logic          valve_open_q, fault_q;
    logic          rise;

    // Next-state decision: transitions, timers and fill counter.
    always_comb begin
        rise         = (level > level_q);
        state_d      = state_q;
        fill_count_d = fill_count_q;
        rise_t_d     = '0;

        unique case (state_q)
            ST_OFF: begin
                if (enable && (level <= LOW_LVL) && (t_q >= MIN_OFF_M1)) begin
                    state_d      = ST_FILL;
                    fill_count_d = fill_count_q + 8'd1;
                end
            end
            ST_FILL: begin
                if (!enable || (level == 3'd7)) begin
                    state_d = ST_OFF;
                end else if (!rise && (level < HIGH_LVL) && (rise_t_q == RISE_TO_M1)) begin
                    state_d = ST_FAULT;
                end else if ((level >= HIGH_LVL) && (t_q >= MIN_ON_M1)) begin
                    state_d = ST_OFF;
                end else if (rise) begin
                    rise_t_d = '0;
                end else begin
                    rise_t_d = (rise_t_q == T_MAX) ? T_MAX : rise_t_q + TW'(1);
                end
            end
            ST_FAULT: begin
                if (fault_clear) begin
                    state_d = ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase

        // Any state change restarts the state timer, so a cleared fault
        // still has to serve the full minimum off time.
        if (state_d != state_q) begin
            t_d = '0;
        end else begin
            t_d = (t_q == T_MAX) ? T_MAX : t_q + TW'(1);
        end
    end

    // State register with outputs registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_OFF;
            t_q          <= T_MAX;
            rise_t_q     <= '0;
            level_q      <= '0;
            fill_count_q <= '0;
            valve_open_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            rise_t_q     <= rise_t_d;
            level_q      <= level;
            fill_count_q <= fill_count_d;
            valve_open_q <= (state_d == ST_FILL);
            fault_q      <= (state_d == ST_FAULT);
        end
    end

    assign valve_open = valve_open_q;
    assign fault      = fault_q;
    assign state      = state_q;
    assign fill_count = fill_count_q;

endmodule

// File: doc/reservoir_fill_controller.md
# reservoir_fill_controller

Closed-loop inlet-valve controller for the irrigation reservoir. It takes the 3-bit water level from the level tracker and drives the inlet valve with hysteresis between a low and a high mark. It enforces minimum valve on and off times, and raises a latched fault when the level does not rise while the valve is open. It sits between the level-tracking FSM and the valve/pump actuator driver.

## Interface
- LOW_MARK, 2: refill when level <= LOW_MARK.
- HIGH_MARK, 6: stop filling when level >= HIGH_MARK. Constraint: LOW_MARK < HIGH_MARK <= 7.
- MIN_ON, 4: minimum cycles the valve stays open. Must be >= 1.
- MIN_OFF, 4: minimum cycles the valve stays closed between fills. Must be >= 1.
- RISE_TIMEOUT, 16: cycles without a level increase in FILL before a fault. Must be >= 1.
- TW, 8: width of the state timer and rise timer. All of MIN_ON, MIN_OFF and RISE_TIMEOUT must be <= 2^TW-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clock clock.
- enable  input  1  irrigation system enable.
- level  input  3  current reservoir level, 0..7, from the level tracker.
- fault_clear  input  1  single-cycle request to leave FAULT.
- valve_open  output  1  inlet valve command, high = open.
- fault  output  1  latched no-rise fault.
- state  output  2  encoded state: OFF=00, FILL=01, FAULT=10.
- fill_count  output  8  number of OFF->FILL transitions, wraps at 255.

## Operation
- Registers:
  - state
  - t: state timer, TW bits, saturating
  - rise_t: rise timer, TW bits, saturating
  - level_q: previous level
  - fill_count
- All outputs decode from registered state only: valve_open = (state==FILL), fault = (state==FAULT).
- t clears to 0 on every state change. Otherwise it increments by 1 per cycle and saturates at 2^TW-1.
- Reset (async): state=OFF, t=2^TW-1 (minimum-off already satisfied), rise_t=0, level_q=0, fill_count=0.
- Reset outputs: valve_open=0, fault=0, state=00, fill_count=0. These appear immediately on reset assertion, with no clock edge.
- level_q <= level every cycle.
- rise: level > level_q. Unsigned 3-bit compare.
- OFF:
  - Go to FILL when enable && level <= LOW_MARK && t >= MIN_OFF-1.
  - On this transition fill_count increments (wraps 255->0) and rise_t clears.
- FILL, with exits checked in priority order:
  1. !enable -> OFF. Overrides MIN_ON.
  2. level==7 -> OFF. Overflow guard; overrides MIN_ON.
  3. !rise && level < HIGH_MARK && rise_t == RISE_TIMEOUT-1 -> FAULT.
  4. level >= HIGH_MARK && t >= MIN_ON-1 -> OFF.
- rise_t in FILL: clears on any cycle with rise; otherwise increments, saturating. Outside FILL it holds at 0.
- FAULT:
  - Valve closed.
  - fault_clear -> OFF, with t cleared, so the full MIN_OFF is enforced.
  - enable has no effect in FAULT.
- fault_clear outside FAULT is ignored.
- A level decrease during FILL is not a rise; rise_t continues counting.

## Timing
- Decision latency is one cycle: an input sampled at edge k changes the outputs after edge k.
- If state is entered at edge e0, the earliest exit governed by a minimum time is edge e0+MIN_* (the valve holds for MIN_* cycles).
- No-rise fault: entry at e0 with no rise → FAULT at edge e0+RISE_TIMEOUT. A rise at edge e0+j restarts the count from that edge.
- First fill after reset: enable=1 and level<=LOW_MARK at the first edge after reset release → valve_open=1 after that edge.
- Reset asserted mid-FILL drops valve_open asynchronously. After release, refill is immediate if the FILL conditions hold (t is saturated).
- Simultaneous enable fall and level==7 in FILL → OFF (same result either way).

## Test plan
- Reset release, enable=1, level=1 → after edge 1: valve_open=1, state=01, fill_count=1.
- FILL, level stepping 2→6 one step every 2 cycles → valve_open=0 on the edge that samples level=6. Level then forced to 1 → valve_open stays 0 for exactly 4 cycles, then goes to 1; fill_count=2.
- FILL with level held at 3 → fault=1, state=10, valve_open=0 at edge 16 after entry. A level rise at cycle 10 postpones the fault to edge 26. A fault_clear pulse → state=00 on the next edge; refill occurs 4 cycles later.
- Level=7 on the first cycle of FILL → valve_open=0 on the next edge, despite MIN_ON=4. Level=6 on the first cycle of FILL → valve stays open until t=3, closing at edge 4.
- enable=0 mid-FILL → valve_open=0 on the next edge. Async reset mid-FILL → valve_open=0 before any edge, fill_count=0.
- 256 complete fill/close cycles → fill_count wraps 255→0. fault_clear pulses in OFF and FILL → no state change.
